mux_arb_n: RTL and testbench
============================

MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 The block SHALL have parameter NPORT, default 2, number of input ports (2..8).
REQ-002 The block SHALL have parameter DATAW, default 66, flit width; top 2 bits are flit type.
REQ-003 The block SHALL have parameter VCHW, default 2, virtual-channel tag width.
REQ-004 The block SHALL have parameter MODE, default 0; 0 = static select via sel, 1 = round-robin arbitration.
REQ-005 The block SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-007 The block SHALL have port idata, input, NPORT*DATAW, input flits; port p occupies bits [p*DATAW +: DATAW].
REQ-008 The block SHALL have port ivalid, input, NPORT, per-port flit valid.
REQ-009 The block SHALL have port ivch, input, NPORT*VCHW, per-port VC tag.
REQ-010 The block SHALL have port iready, output, NPORT, per-port flit accepted this cycle.
REQ-011 The block SHALL have port sel, input, $clog2(NPORT), static port select, used in MODE 0 only.
REQ-012 The block SHALL have ports odata (DATAW), ovalid (1) and ovch (VCHW), all outputs, forming the registered output flit.
REQ-013 The block SHALL have port oready, input, 1, downstream accepts the output flit.
REQ-014 The block SHALL have port ogrant, output, NPORT, one-hot locked port; zero when IDLE.
REQ-015 The block SHALL have port perr, output, 1, sticky protocol-error flag.

Function
REQ-016 The flit type encoding SHALL be NONE=00, HEAD=01, DATA=10, TAIL=11.
REQ-017 Transfer rules SHALL be:
- a transfer on port p occurs when ivalid[p] & iready[p];
- the output transfer occurs when ovalid & oready.
REQ-018 The output register SHALL load when empty or draining (~ovalid | oready).
- latency: exactly 1 cycle from input transfer to ovalid;
- throughput: 1 flit/cycle.
REQ-019 The FSM SHALL have two states, IDLE and LOCKED.
REQ-020 In IDLE, the candidate port SHALL be:
- MODE 0: sel;
- MODE 1: first port with ivalid and a HEAD flit, searching from rr_ptr upward with wrap-around.
REQ-021 IDLE->LOCKED SHALL occur on transfer of a HEAD flit from the candidate port.
- the port is latched into ogrant;
- the HEAD flit is forwarded.
REQ-022 In LOCKED, only the granted port SHALL have iready; flits of any type are forwarded unchanged with their ivch.
REQ-023 LOCKED->IDLE SHALL occur on transfer of a TAIL flit from the granted port.
- MODE 1: rr_ptr <= granted port + 1, modulo NPORT;
- a new HEAD may be granted the following cycle.
REQ-024 In IDLE, a valid non-HEAD flit on the MODE 0 candidate SHALL be consumed (iready=1) and discarded, and SHALL set perr.
REQ-025 In LOCKED, a HEAD flit on the granted port SHALL be forwarded and SHALL set perr.
REQ-026 A sel change while LOCKED SHALL be ignored until return to IDLE.
REQ-027 With oready=0 and ovalid=1, the output flit SHALL hold stable and every iready SHALL be 0.
REQ-028 Non-granted ports SHALL see iready=0 and SHALL never be dropped; they wait.

Reset
REQ-029 On rst, the block SHALL immediately set:
- state=IDLE, rr_ptr=0, ogrant=0, perr=0;
- ovalid=0, odata=0, ovch=0.
REQ-030 Reset mid-packet SHALL abandon the packet; no TAIL is emitted afterward.

Structure
REQ-031 The flit type encodings and TYPEW=2 SHALL reside in the shared package/define file with the existing DATAW/VCHW macros.
REQ-032 The round-robin priority picker SHALL be one sub-module, rr_pick (NPORT-wide request -> one-hot grant from pointer).

Verification
REQ-033 MODE 0, NPORT=2, sel=1: HEAD, 19 DATA and TAIL on port 1 -> 21 flits out in order, 1-cycle latency, ogrant=2'b10, perr=0.
REQ-034 MODE 1, NPORT=4: ports 0 and 2 both present HEAD in the same cycle with rr_ptr=0 -> port 0 packet completes first, then port 2 granted the cycle after port 0's TAIL transfer.
REQ-035 oready held 0 for 5 cycles mid-packet -> odata stable, iready=0, no flit lost or duplicated.
REQ-036 MODE 0: DATA flit on selected port while IDLE -> flit discarded, ovalid stays 0, perr=1 and remains 1.
REQ-037 rst asserted mid-packet, then a new HEAD on port 1 -> all outputs 0 during reset; new packet then forwarded normally.
REQ-038 MODE 1, NPORT=3: all ports continuously request -> grants rotate 0,1,2,0 per packet.

Source files
------------

// File: rtl/mux_arb_n_pkg.sv
// Shared types and constants for the flit multiplexer/arbiter.
package mux_arb_n_pkg;

  // Default flit and virtual-channel widths
  localparam int unsigned DefDataW = 66;
  localparam int unsigned DefVchW  = 2;

  // The flit type sits in the top TYPEW bits of every flit
  localparam int unsigned TYPEW = 2;

  typedef enum logic [TYPEW-1:0] {
    FlitNone = 2'b00,
    FlitHead = 2'b01,
    FlitData = 2'b10,
    FlitTail = 2'b11
  } flit_type_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first asserted request at or above the pointer,
// wrapping around, returned as a one-hot grant.
module rr_pick #(
  parameter int unsigned  NPORT = 2,
  localparam int unsigned PtrW  = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic [NPORT-1:0] req_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic [NPORT-1:0] gnt_o
);

  logic [PtrW:0]   sum;
  logic [PtrW-1:0] idx;
  logic            found;

  // Scan from the pointer upward with wrap-around; stop at the first request
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      sum = {1'b0, ptr_i} + (PtrW + 1)'(i);
      if (sum >= (PtrW + 1)'(NPORT)) begin
        sum = sum - (PtrW + 1)'(NPORT);
      end
      idx = sum[PtrW-1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-port packet multiplexer. A HEAD flit locks one input port until its TAIL
// has passed; the port is chosen statically (MODE 0) or round-robin (MODE 1).
// Output is a single registered flit stage with valid/ready flow control.
module mux_arb_n
  import mux_arb_n_pkg::*;
#(
  parameter int unsigned  NPORT = 2,
  parameter int unsigned  DATAW = DefDataW,
  parameter int unsigned  VCHW  = DefVchW,
  parameter int unsigned  MODE  = 0,
  localparam int unsigned SelW  = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT*DATAW-1:0] idata,
  input  logic [NPORT-1:0]      ivalid,
  input  logic [NPORT*VCHW-1:0] ivch,
  output logic [NPORT-1:0]      iready,
  input  logic [SelW-1:0]       sel,
  output logic [DATAW-1:0]      odata,
  output logic                  ovalid,
  output logic [VCHW-1:0]       ovch,
  input  logic                  oready,
  output logic [NPORT-1:0]      ogrant,
  output logic                  perr
);

  arb_state_e       st_q, st_d;
  logic [NPORT-1:0] grant_q, grant_d;
  logic [SelW-1:0]  gidx_q, gidx_d;
  logic [SelW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             perr_q, perr_d;
  logic [DATAW-1:0] odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic [VCHW-1:0]  ovch_q, ovch_d;

  logic [NPORT-1:0] head_req;
  logic [NPORT-1:0] rr_gnt;
  logic [NPORT-1:0] sel_oh;
  logic [NPORT-1:0] cand_oh;
  logic [SelW-1:0]  cand_idx;
  logic [NPORT-1:0] port_oh;
  logic [SelW-1:0]  port_idx;
  logic [DATAW-1:0] flit;
  logic [VCHW-1:0]  flit_vch;
  flit_type_e       ftype;
  logic             load_en;
  logic             xfer;

  // Ports currently offering a HEAD flit, for round-robin candidacy
  always_comb begin
    head_req = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      head_req[p] = ivalid[p] & (idata[p*DATAW + DATAW - TYPEW +: TYPEW] == FlitHead);
    end
  end

  rr_pick #(
    .NPORT (NPORT)
  ) u_rr_pick (
    .req_i (head_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt)
  );

  // Static select decoded to one-hot; an out-of-range sel selects nothing
  always_comb begin
    sel_oh = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (sel == SelW'(p)) begin
        sel_oh[p] = 1'b1;
      end
    end
  end

  assign cand_oh = (MODE == 1) ? rr_gnt : sel_oh;

  // One-hot candidate to index
  always_comb begin
    cand_idx = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (cand_oh[p]) begin
        cand_idx = SelW'(p);
      end
    end
  end

  // Once locked, only the granted port is served regardless of sel or requests
  assign port_oh  = (st_q == StLocked) ? grant_q : cand_oh;
  assign port_idx = (st_q == StLocked) ? gidx_q  : cand_idx;

  // Output stage can take a flit when empty or draining this cycle
  assign load_en = ~ovalid_q | oready;
  assign iready  = (load_en && !rst) ? port_oh : '0;
  assign xfer    = |(ivalid & iready);

  // Flit and VC tag of the served port
  always_comb begin
    flit     = '0;
    flit_vch = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (port_idx == SelW'(p)) begin
        flit     = idata[p*DATAW +: DATAW];
        flit_vch = ivch[p*VCHW +: VCHW];
      end
    end
  end

  assign ftype = flit_type_e'(flit[DATAW-1 -: TYPEW]);

  // Lock/unlock state machine, output register load and error flag
  always_comb begin
    st_d     = st_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    perr_d   = perr_q;
    odata_d  = odata_q;
    ovch_d   = ovch_q;
    ovalid_d = ovalid_q;
    if (load_en) begin
      ovalid_d = 1'b0;
    end
    unique case (st_q)
      StIdle: begin
        if (xfer) begin
          if (ftype == FlitHead) begin
            ovalid_d = 1'b1;
            odata_d  = flit;
            ovch_d   = flit_vch;
            st_d     = StLocked;
            grant_d  = cand_oh;
            gidx_d   = cand_idx;
          end else begin
            // Stray non-HEAD flit outside a packet: swallow it and flag
            perr_d = 1'b1;
          end
        end
      end
      StLocked: begin
        if (xfer) begin
          ovalid_d = 1'b1;
          odata_d  = flit;
          ovch_d   = flit_vch;
          if (ftype == FlitHead) begin
            perr_d = 1'b1;
          end
          if (ftype == FlitTail) begin
            st_d    = StIdle;
            grant_d = '0;
            if (MODE == 1) begin
              rr_ptr_d = (gidx_q == SelW'(NPORT - 1)) ? '0 : gidx_q + 1'b1;
            end
          end
        end
      end
      default: begin
        st_d = StIdle;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= StIdle;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      perr_q   <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
    end else begin
      st_q     <= st_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      perr_q   <= perr_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;
  assign ogrant = grant_q;
  assign perr   = perr_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: three instances (static MODE 0 with 2 ports, round-robin
// with 4 ports, round-robin with 3 ports) fed from per-port flit queues, with a
// scoreboard of expected output flits per instance.
module tb_mux_arb_n;

  localparam int unsigned DW = 18;
  localparam int unsigned VW = 2;
  localparam int unsigned EW = DW + VW;
  localparam logic [1:0]  TH = 2'b01;
  localparam logic [1:0]  TD = 2'b10;
  localparam logic [1:0]  TT = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: MODE 0, 2 ports
  logic [2*DW-1:0] a_idata;
  logic [1:0]      a_ivalid, a_iready, a_ogrant;
  logic [2*VW-1:0] a_ivch;
  logic [0:0]      a_sel;
  logic [DW-1:0]   a_odata;
  logic            a_ovalid, a_oready, a_perr;
  logic [VW-1:0]   a_ovch;

  // Instance B: MODE 1, 4 ports
  logic [4*DW-1:0] b_idata;
  logic [3:0]      b_ivalid, b_iready, b_ogrant;
  logic [4*VW-1:0] b_ivch;
  logic [1:0]      b_sel;
  logic [DW-1:0]   b_odata;
  logic            b_ovalid, b_oready, b_perr;
  logic [VW-1:0]   b_ovch;

  // Instance C: MODE 1, 3 ports
  logic [3*DW-1:0] c_idata;
  logic [2:0]      c_ivalid, c_iready, c_ogrant;
  logic [3*VW-1:0] c_ivch;
  logic [1:0]      c_sel;
  logic [DW-1:0]   c_odata;
  logic            c_ovalid, c_oready, c_perr;
  logic [VW-1:0]   c_ovch;

  mux_arb_n #(.NPORT(2), .DATAW(DW), .VCHW(VW), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .idata(a_idata), .ivalid(a_ivalid), .ivch(a_ivch),
    .iready(a_iready), .sel(a_sel), .odata(a_odata), .ovalid(a_ovalid), .ovch(a_ovch),
    .oready(a_oready), .ogrant(a_ogrant), .perr(a_perr)
  );

  mux_arb_n #(.NPORT(4), .DATAW(DW), .VCHW(VW), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .idata(b_idata), .ivalid(b_ivalid), .ivch(b_ivch),
    .iready(b_iready), .sel(b_sel), .odata(b_odata), .ovalid(b_ovalid), .ovch(b_ovch),
    .oready(b_oready), .ogrant(b_ogrant), .perr(b_perr)
  );

  mux_arb_n #(.NPORT(3), .DATAW(DW), .VCHW(VW), .MODE(1)) u_c (
    .clk(clk), .rst(rst), .idata(c_idata), .ivalid(c_ivalid), .ivch(c_ivch),
    .iready(c_iready), .sel(c_sel), .odata(c_odata), .ovalid(c_ovalid), .ovch(c_ovch),
    .oready(c_oready), .ogrant(c_ogrant), .perr(c_perr)
  );

  // Per-port source queues and per-instance expected-output queues ({flit, vch})
  logic [EW-1:0] asrc[2][$];
  logic [EW-1:0] bsrc[4][$];
  logic [EW-1:0] csrc[3][$];
  logic [EW-1:0] qa[$];
  logic [EW-1:0] qb[$];
  logic [EW-1:0] qc[$];
  logic [EW-1:0] ev[32];

  function automatic logic [EW-1:0] fl(input logic [1:0] t, input logic [15:0] pl,
                                       input logic [VW-1:0] v);
    return {t, pl, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsz(input int which);
    case (which)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  // Wait (bounded) until an instance's scoreboard has been fully consumed
  task automatic drain(input int which, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (qsz(which) == 0) break;
      @(negedge clk);
      #1;
    end
    chk(tag, 64'(qsz(which)), 64'(0));
  endtask

  // Sources: present queue heads; pop after a handshake seen before the edge
  initial begin : src_a
    logic [1:0] acc;
    a_ivalid = '0; a_idata = '0; a_ivch = '0;
    forever begin
      @(negedge clk);
      acc = a_ivalid & a_iready;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (acc[p] && asrc[p].size() != 0) void'(asrc[p].pop_front());
        if (asrc[p].size() != 0) begin
          a_idata[p*DW +: DW] = asrc[p][0][EW-1:VW];
          a_ivch[p*VW +: VW]  = asrc[p][0][VW-1:0];
          a_ivalid[p]         = 1'b1;
        end else begin
          a_ivalid[p] = 1'b0;
        end
      end
    end
  end

  initial begin : src_b
    logic [3:0] acc;
    b_ivalid = '0; b_idata = '0; b_ivch = '0;
    forever begin
      @(negedge clk);
      acc = b_ivalid & b_iready;
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        if (acc[p] && bsrc[p].size() != 0) void'(bsrc[p].pop_front());
        if (bsrc[p].size() != 0) begin
          b_idata[p*DW +: DW] = bsrc[p][0][EW-1:VW];
          b_ivch[p*VW +: VW]  = bsrc[p][0][VW-1:0];
          b_ivalid[p]         = 1'b1;
        end else begin
          b_ivalid[p] = 1'b0;
        end
      end
    end
  end

  initial begin : src_c
    logic [2:0] acc;
    c_ivalid = '0; c_idata = '0; c_ivch = '0;
    forever begin
      @(negedge clk);
      acc = c_ivalid & c_iready;
      @(posedge clk);
      #1;
      for (int p = 0; p < 3; p++) begin
        if (acc[p] && csrc[p].size() != 0) void'(csrc[p].pop_front());
        if (csrc[p].size() != 0) begin
          c_idata[p*DW +: DW] = csrc[p][0][EW-1:VW];
          c_ivch[p*VW +: VW]  = csrc[p][0][VW-1:0];
          c_ivalid[p]         = 1'b1;
        end else begin
          c_ivalid[p] = 1'b0;
        end
      end
    end
  end

  // Output monitor: every output handshake must match the next expected flit
  initial begin : mon
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && a_ovalid && a_oready) begin
        chk("a_sb_pending", 64'(qa.size() != 0), 64'(1));
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk("a_sb_flit", 64'({a_odata, a_ovch}), 64'(e));
        end
      end
      if (!rst && b_ovalid && b_oready) begin
        chk("b_sb_pending", 64'(qb.size() != 0), 64'(1));
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk("b_sb_flit", 64'({b_odata, b_ovch}), 64'(e));
        end
      end
      if (!rst && c_ovalid && c_oready) begin
        chk("c_sb_pending", 64'(qc.size() != 0), 64'(1));
        if (qc.size() != 0) begin
          e = qc.pop_front();
          chk("c_sb_flit", 64'({c_odata, c_ovch}), 64'(e));
        end
      end
    end
  end

  initial begin : main
    logic [1:0] t;
    logic [3:0] gexp[7];
    a_sel = 1'b1; a_oready = 1'b1;
    b_sel = '0;   b_oready = 1'b1;
    c_sel = '0;   c_oready = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_a_ovalid", 64'(a_ovalid), 64'(0));
    chk("rst_a_odata",  64'(a_odata),  64'(0));
    chk("rst_a_ovch",   64'(a_ovch),   64'(0));
    chk("rst_a_ogrant", 64'(a_ogrant), 64'(0));
    chk("rst_a_perr",   64'(a_perr),   64'(0));
    chk("rst_a_iready", 64'(a_iready), 64'(0));
    chk("rst_b_ovalid", 64'(b_ovalid), 64'(0));
    chk("rst_c_ogrant", 64'(c_ogrant), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // MODE 0, sel=1: 21-flit packet streams with 1-cycle latency
    @(negedge clk);
    for (int k = 0; k < 21; k++) begin
      t = (k == 0) ? TH : ((k == 20) ? TT : TD);
      ev[k] = fl(t, 16'h1000 + 16'(k), 2'd3);
      asrc[1].push_back(ev[k]);
      qa.push_back(ev[k]);
    end
    @(posedge clk);
    @(posedge clk);
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      chk("t1_ovalid", 64'(a_ovalid), 64'(1));
      chk("t1_odata",  64'({a_odata, a_ovch}), 64'(ev[k]));
      chk("t1_ogrant", 64'(a_ogrant), 64'((k == 20) ? 2'b00 : 2'b10));
    end
    drain(0, "t1_drain");
    chk("t1_perr", 64'(a_perr), 64'(0));

    // MODE 0: DATA flit while idle is swallowed and sets a sticky error
    @(negedge clk);
    asrc[1].push_back(fl(TD, 16'h2000, 2'd1));
    @(posedge clk);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("t2_ovalid", 64'(a_ovalid), 64'(0));
      chk("t2_perr",   64'(a_perr),   64'(1));
    end
    chk("t2_consumed", 64'(asrc[1].size()), 64'(0));
    chk("t2_ogrant",   64'(a_ogrant),       64'(0));
    repeat (4) @(negedge clk);
    chk("t2_perr_sticky", 64'(a_perr), 64'(1));

    // Output stall for 5 cycles mid-packet; sel moved away while locked
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      t = (k == 0) ? TH : ((k == 9) ? TT : TD);
      ev[k] = fl(t, 16'h3000 + 16'(k), 2'd2);
      asrc[1].push_back(ev[k]);
      qa.push_back(ev[k]);
    end
    @(posedge clk);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_odata", 64'({a_odata, a_ovch}), 64'(ev[k]));
    end
    @(posedge clk);
    #1;
    a_oready = 1'b0;
    a_sel    = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("t3_hold_data",   64'({a_odata, a_ovch}), 64'(ev[3]));
      chk("t3_hold_valid",  64'(a_ovalid), 64'(1));
      chk("t3_hold_iready", 64'(a_iready), 64'(0));
    end
    @(posedge clk);
    #1;
    a_oready = 1'b1;
    drain(0, "t3_drain");
    chk("t3_ogrant_idle", 64'(a_ogrant), 64'(0));
    @(posedge clk);
    #1;
    a_sel = 1'b1;

    // Reset mid-packet, then a fresh packet on port 1
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      t = (k == 0) ? TH : TD;
      asrc[1].push_back(fl(t, 16'h4000 + 16'(k), 2'd1));
      qa.push_back(fl(t, 16'h4000 + 16'(k), 2'd1));
    end
    drain(0, "t4_pre_drain");
    chk("t4_locked_grant", 64'(a_ogrant), 64'(2'b10));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t4_rst_ovalid", 64'(a_ovalid), 64'(0));
    chk("t4_rst_odata",  64'(a_odata),  64'(0));
    chk("t4_rst_ovch",   64'(a_ovch),   64'(0));
    chk("t4_rst_ogrant", 64'(a_ogrant), 64'(0));
    chk("t4_rst_perr",   64'(a_perr),   64'(0));
    chk("t4_rst_iready", 64'(a_iready), 64'(0));
    @(negedge clk);
    chk("t4_rst_hold_grant", 64'(a_ogrant), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      t = (k == 0) ? TH : ((k == 2) ? TT : TD);
      asrc[1].push_back(fl(t, 16'h5000 + 16'(k), 2'd3));
      qa.push_back(fl(t, 16'h5000 + 16'(k), 2'd3));
    end
    drain(0, "t4_post_drain");
    repeat (3) @(negedge clk);
    chk("t4_post_ogrant", 64'(a_ogrant), 64'(0));
    chk("t4_post_perr",   64'(a_perr),   64'(0));
    chk("t4_no_extra",    64'(qa.size()), 64'(0));

    // MODE 1, 4 ports: ports 0 and 2 HEAD together, port 0 wins, port 2 next
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      t = (k == 0) ? TH : ((k == 3) ? TT : TD);
      ev[k] = fl(t, 16'h6000 + 16'(k), 2'd0);
      bsrc[0].push_back(ev[k]);
      qb.push_back(ev[k]);
    end
    for (int k = 0; k < 3; k++) begin
      t = (k == 0) ? TH : ((k == 2) ? TT : TD);
      ev[4+k] = fl(t, 16'h6200 + 16'(k), 2'd2);
      bsrc[2].push_back(ev[4+k]);
      qb.push_back(ev[4+k]);
    end
    gexp[0] = 4'b0001; gexp[1] = 4'b0001; gexp[2] = 4'b0001; gexp[3] = 4'b0000;
    gexp[4] = 4'b0100; gexp[5] = 4'b0100; gexp[6] = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t5_ovalid", 64'(b_ovalid), 64'(1));
      chk("t5_odata",  64'({b_odata, b_ovch}), 64'(ev[k]));
      chk("t5_ogrant", 64'(b_ogrant), 64'(gexp[k]));
      if (k == 1) chk("t5_iready_locked", 64'(b_iready), 64'(4'b0001));
    end
    drain(1, "t5_drain");
    chk("t5_perr", 64'(b_perr), 64'(0));

    // MODE 1, 3 ports all requesting: packets rotate 0,1,2,0,1,2
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 3; p++) begin
        for (int k = 0; k < 3; k++) begin
          t = (k == 0) ? TH : ((k == 2) ? TT : TD);
          csrc[p].push_back(fl(t, 16'h7000 + 16'(r * 256 + p * 16 + k), 2'(p)));
          qc.push_back(fl(t, 16'h7000 + 16'(r * 256 + p * 16 + k), 2'(p)));
        end
      end
    end
    drain(2, "t6_drain");
    repeat (2) @(negedge clk);
    chk("t6_ogrant_idle", 64'(c_ogrant), 64'(0));
    chk("t6_perr",        64'(c_perr),   64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
